// File: rtl/hit_reaction.sv
// hit_reaction: receiving end of the punch interface for one fighter.
// It turns an accepted one-frame hit pulse into knockback motion, hitstun,
// health loss and a sticky knockout. One instance per fighter, clocked by frame_clk.
//
// Optional feature: define HIT_REACTION_BLOCK_EN to add the Block input.
// A hit taken from IDLE while Block=1 does half damage, uses a shorter
// knockback and skips hitstun recovery.
//
// Ports:
//   frame_clk      in   frame clock, the only clock
//   Reset          in   synchronous, active-high reset
//   Punch          in   hit pulse, sampled every frame
//   Dir            in   push direction at hit time (1 = +X, 0 = -X)
//   Xpos           in   current fighter X position (signed)
//   Ball_X_Motion  out  per-frame X displacement (signed)
//   HitStun        out  high during knockback and recovery
//   Health         out  remaining health
//   Hit_Ack        out  one-frame pulse per accepted hit
//   KO             out  sticky knockout flag
//   Block          in   (HIT_REACTION_BLOCK_EN only) guard held by the fighter
module hit_reaction #(
  parameter int KNOCK_SPEED    = 4,
  parameter int KNOCK_FRAMES   = 8,
  parameter int RECOVER_FRAMES = 12,
  parameter int MAX_HEALTH     = 100,
  parameter int DAMAGE         = 10,
  parameter int X_MIN          = 10,
  parameter int X_MAX          = 560
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               Punch,
  input  logic               Dir,
  input  logic signed [31:0] Xpos,
  output logic signed [31:0] Ball_X_Motion,
  output logic               HitStun,
  output logic [7:0]         Health,
  output logic               Hit_Ack,
  output logic               KO
`ifdef HIT_REACTION_BLOCK_EN
  ,
  input  logic               Block
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KNOCK   = 2'd1,
    S_RECOVER = 2'd2,
    S_KO      = 2'd3
  } state_t;

  localparam int CNT_W      = 16;
  localparam int BLK_FRAMES = (KNOCK_FRAMES / 2 < 1) ? 1 : KNOCK_FRAMES / 2;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               dir_q, dir_next;
  logic               blocked_q, blocked_next;
  logic [7:0]         health_next;
  logic [7:0]         health_hit;
  logic               ack_next;
  logic               block_hit;

  // Health subtraction in 9 bits; a borrow into bit 8 means it went negative.
  function automatic logic [7:0] sat_health(input logic [7:0] h, input int dmg);
    logic [8:0] diff;
    diff = {1'b0, h} - 9'(dmg);
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

  // Knockback step limited by the distance left to the wall in the push
  // direction; a fighter at or beyond the wall does not move.
  function automatic logic signed [31:0] clamp_motion(input logic d,
                                                      input logic signed [31:0] x);
    logic signed [31:0] room;
    logic signed [31:0] step;
    room = d ? (X_MAX - x) : (x - X_MIN);
    step = (room < KNOCK_SPEED) ? room : KNOCK_SPEED;
    if (step < 0) step = 0;
    return d ? step : -step;
  endfunction

`ifdef HIT_REACTION_BLOCK_EN
  // Blocking only works from a neutral stance, never out of hitstun.
  assign block_hit = Block && (state == S_IDLE);
`else
  assign block_hit = 1'b0;
`endif

  assign health_hit = sat_health(Health, block_hit ? DAMAGE / 2 : DAMAGE);

  // State register
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dir_q     <= 1'b0;
      blocked_q <= 1'b0;
      Health    <= 8'(MAX_HEALTH);
      Hit_Ack   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      dir_q     <= dir_next;
      blocked_q <= blocked_next;
      Health    <= health_next;
      Hit_Ack   <= ack_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    dir_next     = dir_q;
    blocked_next = blocked_q;
    health_next  = Health;
    ack_next     = 1'b0;
    case (state)
      S_IDLE, S_RECOVER: begin
        if (Punch) begin
          // Accepted hit; from RECOVER this is a combo restarting knockback.
          health_next  = health_hit;
          ack_next     = 1'b1;
          dir_next     = Dir;
          blocked_next = block_hit;
          if (health_hit == 8'd0) begin
            state_next = S_KO;
            cnt_next   = '0;
          end else begin
            state_next = S_KNOCK;
            cnt_next   = block_hit ? CNT_W'(BLK_FRAMES - 1) : CNT_W'(KNOCK_FRAMES - 1);
          end
        end else if (state == S_RECOVER) begin
          if (cnt == '0) state_next = S_IDLE;
          else           cnt_next   = cnt - CNT_W'(1);
        end
      end
      S_KNOCK: begin
        // Punch is ignored here: no damage, no ack, no restart.
        if (cnt == '0) begin
          if (blocked_q) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            state_next = S_RECOVER;
            cnt_next   = CNT_W'(RECOVER_FRAMES - 1);
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = S_KO;
      end
    endcase
  end

  // Outputs
  always_comb begin
    Ball_X_Motion = '0;
    HitStun       = 1'b0;
    KO            = 1'b0;
    case (state)
      S_KNOCK: begin
        Ball_X_Motion = clamp_motion(dir_q, Xpos);
        HitStun       = 1'b1;
      end
      S_RECOVER: HitStun = 1'b1;
      S_KO:      KO      = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_hit_reaction.sv
module tb_hit_reaction;

  localparam int KS  = 4;
  localparam int KF  = 8;
  localparam int RF  = 12;
  localparam int MH  = 100;
  localparam int DMG = 10;
  localparam int XL  = 10;
  localparam int XR  = 560;

  logic               frame_clk = 1'b0;
  logic               Reset = 1'b1;
  logic               Punch = 1'b0;
  logic               Dir = 1'b0;
  logic signed [31:0] Xpos = 300;
  logic               Block = 1'b0;
  logic signed [31:0] Ball_X_Motion;
  logic               HitStun;
  logic [7:0]         Health;
  logic               Hit_Ack;
  logic               KO;

  int errors = 0;
  int checks = 0;

  hit_reaction #(
    .KNOCK_SPEED(KS), .KNOCK_FRAMES(KF), .RECOVER_FRAMES(RF),
    .MAX_HEALTH(MH), .DAMAGE(DMG), .X_MIN(XL), .X_MAX(XR)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .Punch(Punch),
    .Dir(Dir),
    .Xpos(Xpos),
    .Ball_X_Motion(Ball_X_Motion),
    .HitStun(HitStun),
    .Health(Health),
    .Hit_Ack(Hit_Ack),
    .KO(KO)
`ifdef HIT_REACTION_BLOCK_EN
    ,
    .Block(Block)
`endif
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a hit opens a window of kb_len knockback frames followed
  // by rec_len hitstun frames, counted in edges since the accepting edge.
  int health_m = MH;
  bit ko_m = 0;
  bit ack_m = 0;
  int t_m = -1;
  bit dir_m = 0;
  int kb_len_m = KF;
  int rec_len_m = RF;
  bit valid_m = 0;

  function automatic int wall_step(input bit d, input int x);
    int lim;
    lim = d ? (XR - x) : (x - XL);
    if (lim <= 0) return 0;
    if (lim > KS) lim = KS;
    return d ? lim : -lim;
  endfunction

  always @(posedge frame_clk) begin
    bit in_kb, in_rec, blk;
    int dmg;
    if (Reset) begin
      health_m = MH; ko_m = 0; ack_m = 0; t_m = -1; valid_m = 1;
    end else if (valid_m) begin
      in_kb  = (t_m >= 0) && (t_m < kb_len_m);
      in_rec = (t_m >= kb_len_m) && (t_m < kb_len_m + rec_len_m);
      ack_m = 0;
      if (Punch && !ko_m && !in_kb) begin
        blk = Block && !in_rec;
        dmg = blk ? DMG / 2 : DMG;
        health_m = (health_m > dmg) ? health_m - dmg : 0;
        ack_m = 1;
        if (health_m == 0) begin
          ko_m = 1; t_m = -1;
        end else begin
          t_m = 0; dir_m = Dir;
          kb_len_m  = blk ? ((KF / 2 < 1) ? 1 : KF / 2) : KF;
          rec_len_m = blk ? 0 : RF;
        end
      end else if (t_m >= 0) begin
        t_m++;
        if (t_m >= kb_len_m + rec_len_m) t_m = -1;
      end
    end
    #2;
    if (valid_m) begin
      in_kb  = (t_m >= 0) && (t_m < kb_len_m);
      in_rec = (t_m >= kb_len_m) && (t_m < kb_len_m + rec_len_m);
      chk("model_motion", Ball_X_Motion, in_kb ? wall_step(dir_m, Xpos) : 0);
      chk("model_hitstun", HitStun, int'(in_kb || in_rec));
      chk("model_health", Health, health_m);
      chk("model_ack", Hit_Ack, int'(ack_m));
      chk("model_ko", KO, int'(ko_m));
    end
  end

  // One frame of stimulus, applied on the falling edge.
  task automatic cyc(input bit r, input bit p, input bit d, input int x);
    @(negedge frame_clk);
    Reset = r; Punch = p; Dir = d; Xpos = x;
  endtask

  task automatic settle();
    @(posedge frame_clk);
    #3;
  endtask

  task automatic idle(input int n, input int x);
    for (int i = 0; i < n; i++) cyc(0, 0, Dir, x);
  endtask

  initial begin
    cyc(1, 0, 0, 300);
    cyc(1, 0, 0, 300);
    settle();
    chk("reset_health", Health, 100);
    chk("reset_ko", KO, 0);
    chk("reset_motion", Ball_X_Motion, 0);
    chk("reset_hitstun", HitStun, 0);
    chk("reset_ack", Hit_Ack, 0);

    // First hit, with pulses ignored during knockback
    cyc(0, 1, 1, 300);
    settle();
    chk("hit1_health", Health, 90);
    chk("hit1_ack", Hit_Ack, 1);
    chk("hit1_motion", Ball_X_Motion, 4);
    chk("hit1_hitstun", HitStun, 1);
    cyc(0, 0, 1, 300);
    cyc(0, 1, 1, 300);
    cyc(0, 0, 1, 300);
    cyc(0, 0, 1, 300);
    cyc(0, 1, 1, 300);
    cyc(0, 0, 1, 300);
    cyc(0, 0, 1, 300);
    settle();
    chk("kb_last_motion", Ball_X_Motion, 4);
    chk("kb_ignored_health", Health, 90);
    cyc(0, 0, 1, 300);
    settle();
    chk("rec_motion", Ball_X_Motion, 0);
    chk("rec_hitstun", HitStun, 1);

    // Combo on recovery frame 3 with the opposite direction
    cyc(0, 0, 1, 300);
    cyc(0, 0, 1, 300);
    cyc(0, 1, 0, 300);
    settle();
    chk("combo_health", Health, 80);
    chk("combo_motion", Ball_X_Motion, -4);
    chk("combo_ack", Hit_Ack, 1);
    idle(25, 300);
    settle();
    chk("combo_done_hitstun", HitStun, 0);

    // Right wall
    cyc(0, 1, 1, 558);
    settle();
    chk("wall_558", Ball_X_Motion, 2);
    cyc(0, 0, 1, 560);
    settle();
    chk("wall_560", Ball_X_Motion, 0);
    idle(6, 560);
    cyc(0, 0, 1, 565);
    settle();
    chk("wall_rec_hitstun", HitStun, 1);
    idle(13, 300);

    // Left wall
    cyc(0, 1, 0, 12);
    settle();
    chk("lwall_12", Ball_X_Motion, -2);
    cyc(0, 0, 0, 5);
    idle(22, 300);

    // Reset aborts knockback
    cyc(0, 1, 1, 300);
    idle(2, 300);
    cyc(1, 0, 1, 300);
    settle();
    chk("abort_health", Health, 100);
    chk("abort_hitstun", HitStun, 0);
    cyc(0, 0, 1, 300);

    // Ten hits to KO, chained through recovery combos
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, (i % 2) == 0, 300);
      if (i < 9) idle(9, 300);
    end
    settle();
    chk("ko_health", Health, 0);
    chk("ko_flag", KO, 1);
    chk("ko_motion", Ball_X_Motion, 0);
    cyc(0, 1, 1, 300);
    cyc(0, 0, 1, 300);
    cyc(0, 1, 0, 300);
    settle();
    chk("ko_sticky", KO, 1);
    chk("ko_no_ack", Hit_Ack, 0);
    cyc(1, 0, 0, 300);
    settle();
    chk("ko_reset_health", Health, 100);
    chk("ko_reset_flag", KO, 0);

    // Reset dominates a simultaneous Punch
    cyc(0, 1, 1, 300);
    cyc(1, 1, 1, 300);
    settle();
    chk("rst_punch_health", Health, 100);
    chk("rst_punch_ack", Hit_Ack, 0);
    cyc(0, 0, 1, 300);

`ifdef HIT_REACTION_BLOCK_EN
    Block = 1'b1;
    cyc(0, 1, 0, 300);
    settle();
    chk("blk_health", Health, 95);
    chk("blk_motion", Ball_X_Motion, -4);
    idle(3, 300);
    settle();
    chk("blk_kb_last", Ball_X_Motion, -4);
    cyc(0, 0, 0, 300);
    settle();
    chk("blk_no_recover", HitStun, 0);
    Block = 1'b0;
    cyc(0, 1, 1, 300);
    idle(8, 300);
    Block = 1'b1;
    cyc(0, 1, 1, 300);
    settle();
    chk("blk_ignored_in_rec", Health, 75);
    Block = 1'b0;
    idle(22, 300);
`endif

    idle(2, 300);
    @(negedge frame_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
